// File: rtl/fifo_write_arbiter_pkg.sv
// fifo_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
//   arb_state_e : arbiter FSM state encoding (IDLE / GRANT)
//   idx_w()     : width of an index or counter holding values 0..n-1
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Never narrower than one bit so degenerate sizes still give a legal vector.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: producer streams plus the FIFO write port.
//   req_valid/req_data/req_last/req_ready : NUM_REQ valid/ready producer streams,
//                                           lane i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full/fifo_wr_en/fifo_din         : sync_fifo write side
// master = producers + FIFO (environment), slave = the arbiter.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_full;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_din;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_din
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_din
  );
endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// rr_pick: combinational rotate-from-pointer priority encoder.
//   req_valid : request vector
//   rr_ptr    : index that has highest priority this round
//   pick_idx  : first set request scanning upward from rr_ptr, wrapping
//   pick_vld  : any request set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_vld
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit to rr_ptr wins.
  // Modulo keeps the wrap correct for non-power-of-two NUM_REQ.
  always_comb begin
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin share of one sync_fifo write port between
// NUM_REQ producers, bursts of at most BURST_LEN words per grant.
//   clk, reset : clock, async active-high reset
//   bus        : producer streams + FIFO write port (slave side)
//   grant_id   : current / last granted requester
//   busy       : high while a grant is held
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  fifo_write_arbiter_if.slave         bus,
  output logic [idx_w(NUM_REQ)-1:0]   grant_id,
  output logic                        busy
);

  localparam int GID_W  = idx_w(NUM_REQ);
  localparam int BCNT_W = idx_w(BURST_LEN + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);
  localparam logic [GID_W-1:0]  MAX_ID    = GID_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [BCNT_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [GID_W-1:0]   pick_idx;
  logic               pick_vld;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] data_arr;
  logic               g_valid, g_last, xfer, burst_end;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(GID_W)) u_pick (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick_idx  (pick_idx),
    .pick_vld  (pick_vld)
  );

  assign data_arr = bus.req_data;
  assign g_valid  = bus.req_valid[grant_id_q];
  assign g_last   = bus.req_last[grant_id_q];
  // fifo_full gates the transfer combinationally so a full flag rising in a
  // grant cycle never lets a word through.
  assign xfer     = (state_q == ARB_GRANT) && g_valid && !bus.fifo_full;
  // Release (valid dropped) ends the burst without a transfer; a stall on
  // fifo_full alone never ends it.
  assign burst_end = (state_q == ARB_GRANT) &&
                     (!g_valid || (xfer && (g_last || beat_cnt_q == LAST_BEAT)));

  always_comb begin
    bus.req_ready = '0;
    if (state_q == ARB_GRANT) bus.req_ready[grant_id_q] = !bus.fifo_full;
  end

  assign bus.fifo_wr_en = xfer;
  assign bus.fifo_din   = data_arr[grant_id_q];
  assign grant_id       = grant_id_q;
  assign busy           = (state_q == ARB_GRANT);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          state_d    = ARB_GRANT;
          grant_id_d = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (xfer) beat_cnt_d = beat_cnt_q + 1'b1;
        if (burst_end) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (grant_id_q == MAX_ID) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
